// File: rtl/seg_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl: 4-digit common-anode scan controller with guard intervals,  |
// | double-buffered display registers and a load/ready handshake.              |
// | Optional macro: SEG_LEADING_ZERO_BLANK_EN (auto-blank leading zeros).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  dp_mask,
  output logic        ready,
  output logic [3:0]  digit_num,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_val_q, act_val_d, sh_val_q, sh_val_d;
  logic [3:0]       act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic [3:0]       act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic             ready_q, ready_d;
  logic [3:0]       digit_num_q, digit_num_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;
  logic             boundary;
  logic [3:0]       blank_eff;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    act_val_d   = act_val_q;
    act_blank_d = act_blank_q;
    act_dp_d    = act_dp_q;
    sh_val_d    = sh_val_q;
    sh_blank_d  = sh_blank_q;
    sh_dp_d     = sh_dp_q;
    ready_d     = ready_q;

    boundary = (state_q == ST_DRIVE) && (idx_q == 2'd3) && (cnt_q == DRIVE_LAST);

    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase

    // A pending shadow is promoted at the boundary; a load arriving on the
    // same edge (only possible when nothing is pending) waits a full frame.
    if (boundary && !ready_q) begin
      act_val_d   = sh_val_q;
      act_blank_d = sh_blank_q;
      act_dp_d    = sh_dp_q;
      ready_d     = 1'b1;
    end
    if (load && ready_q) begin
      sh_val_d   = value;
      sh_blank_d = blank_mask;
      sh_dp_d    = dp_mask;
      ready_d    = 1'b0;
    end

    blank_eff = act_blank_d;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank_eff[3] = blank_eff[3] | (act_val_d[15:12] == 4'h0);
    blank_eff[2] = blank_eff[2] | (act_val_d[15:8] == 8'h00);
    blank_eff[1] = blank_eff[1] | (act_val_d[15:4] == 12'h000);
`endif

    // Outputs are computed from next-state values so the registered outputs
    // line up with the state they describe.
    digit_num_d = act_val_d[{idx_d, 2'b00} +: 4];
    an_d        = 4'b1111;
    dp_d        = 1'b1;
    if ((state_d == ST_DRIVE) && !blank_eff[idx_d]) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~act_dp_d[idx_d];
    end
    frame_tick_d = (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == DRIVE_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_GUARD;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_val_q    <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      sh_val_q     <= '0;
      sh_blank_q   <= '0;
      sh_dp_q      <= '0;
      ready_q      <= 1'b1;
      digit_num_q  <= '0;
      an_q         <= 4'b1111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      act_dp_q     <= act_dp_d;
      sh_val_q     <= sh_val_d;
      sh_blank_q   <= sh_blank_d;
      sh_dp_q      <= sh_dp_d;
      ready_q      <= ready_d;
      digit_num_q  <= digit_num_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign ready      = ready_q;
  assign digit_num  = digit_num_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with DIGIT_CYCLES=4, GUARD_CYCLES=2 (24-cycle frame).
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int G = 2;
  localparam int SLOT = G + D;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic        ready;
  logic [3:0]  digit_num;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  seg_scan_ctrl #(.DIGIT_CYCLES(D), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .ready(ready),
    .digit_num(digit_num), .an(an), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [3:0] dn;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_val, s_val;
  logic [3:0]  m_bl, m_dp, s_bl, s_dp;
  logic        m_rdy;
  int          mt;

  function automatic exp_t model_out();
    exp_t e;
    int idx = mt / SLOT;
    int pos = mt % SLOT;
    logic guard = (pos < G);
    logic blank = m_bl[idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx > 0 && ((m_val >> (4 * idx)) == 16'h0)) blank = 1'b1;
`endif
    e.an  = (guard || blank) ? 4'b1111 : ~(4'b0001 << idx);
    e.dp  = (guard || blank) ? 1'b1 : ~m_dp[idx];
    e.dn  = m_val[idx*4 +: 4];
    e.ft  = (mt == FRAME - 1);
    e.rdy = m_rdy;
    return e;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks += 5;
      assert (an === e.an) else begin
        failures++; $error("FAIL %s_an t=%0d observed=%b expected=%b", tag, mt, an, e.an);
      end
      assert (dp === e.dp) else begin
        failures++; $error("FAIL %s_dp t=%0d observed=%b expected=%b", tag, mt, dp, e.dp);
      end
      assert (digit_num === e.dn) else begin
        failures++; $error("FAIL %s_digit t=%0d observed=%h expected=%h", tag, mt, digit_num, e.dn);
      end
      assert (frame_tick === e.ft) else begin
        failures++; $error("FAIL %s_tick t=%0d observed=%b expected=%b", tag, mt, frame_tick, e.ft);
      end
      assert (ready === e.rdy) else begin
        failures++; $error("FAIL %s_ready t=%0d observed=%b expected=%b", tag, mt, ready, e.rdy);
      end
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare after it.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] b,
                     input logic [3:0] d, input string tag);
    logic nrdy;
    load = ld; value = v; blank_mask = b; dp_mask = d;
    nrdy = m_rdy;
    if (mt == FRAME - 1 && !m_rdy) begin
      m_val = s_val; m_bl = s_bl; m_dp = s_dp; nrdy = 1'b1;
    end
    if (ld && m_rdy) begin
      s_val = v; s_bl = b; s_dp = d; nrdy = 1'b0;
    end
    m_rdy = nrdy;
    mt = (mt + 1) % FRAME;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    check(tag);
    load = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0, 4'h0, tag);
  endtask

  task automatic idle_until(input int target, input string tag);
    for (int i = 0; i < FRAME && mt != target; i++) cyc(1'b0, 16'h0, 4'h0, 4'h0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; load = 1'b0;
    m_val = '0; s_val = '0; m_bl = '0; s_bl = '0; m_dp = '0; s_dp = '0;
    m_rdy = 1'b1; mt = 0;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    check(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    mt = 0;
    #2;
    // Reset then two idle frames: scan pattern and frame_tick at 23/47
    do_reset("reset");
    idle(2 * FRAME, "idle");

    // Load at cycle 5, shown from frame 1; second load while busy ignored
    do_reset("reset2");
    idle(5, "pre_load");
    cyc(1'b1, 16'hA3F1, 4'h0, 4'h0, "load_a3f1");
    idle(3, "wait");
    cyc(1'b1, 16'h1234, 4'h0, 4'h0, "load_ignored");
    idle(FRAME + 10, "show_a3f1");

    // Load on the frame_tick cycle is deferred one full frame
    idle_until(FRAME - 1, "to_tick");
    cyc(1'b1, 16'h00C0, 4'b0001, 4'h0, "load_on_tick");
    idle(2 * FRAME, "blank0");

    // Decimal point on digit 2 only
    cyc(1'b1, 16'h5678, 4'h0, 4'b0100, "load_dp");
    idle(2 * FRAME, "dp2");

    // Reset mid-DRIVE of digit 2 with a pending shadow
    idle_until(0, "align");
    cyc(1'b1, 16'h9999, 4'h0, 4'hF, "load_pending");
    idle_until(15, "to_drive2");
    do_reset("reset_mid");
    idle(FRAME, "after_reset");

    // Value with leading zeros (auto-blanked only when the feature is built in)
    cyc(1'b1, 16'h0050, 4'h0, 4'h0, "load_0050");
    idle(2 * FRAME, "lzb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one hex-to-seven-segment decoder across a 4-digit common-anode display.
- Holds a 16-bit display value and presents one nibble at a time to the decoder on `digit_num`.
- Drives active-low anodes and decimal point, and inserts an all-off guard interval between digits to prevent ghosting.
- Display updates are double-buffered through a load/ready handshake and take effect only at frame boundaries, so the display never tears.

Parameters:
- DIGIT_CYCLES, 100000, clock cycles each digit is driven (DRIVE state); minimum 1.
- GUARD_CYCLES, 1000, clock cycles all anodes are off before each digit (GUARD state); minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- load  input  1  request to capture value/blank_mask/dp_mask into shadow registers.
- value  input  16  four hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
- blank_mask  input  4  bit k=1 keeps digit k dark.
- dp_mask  input  4  bit k=1 lights the decimal point on digit k.
- ready  output  1  high when the shadow register is free and load will be accepted.
- digit_num  output  4  nibble for the decoder's num input.
- an  output  4  anode enables, active-low, an[k] for digit k.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse on the last DRIVE cycle of digit 3.

Behaviour:
- Reset (rst_n=0 at a clock edge), regardless of current state:
  - state=GUARD, digit index=0, cycle counter=0.
  - Active and shadow value, blank and dp registers cleared to 0.
  - an=4'b1111, dp=1, digit_num=0, ready=1, frame_tick=0.
- Every output is registered.
- State machine, two states:
  - GUARD: an=4'b1111, dp=1, digit_num=active nibble of the current index. Lasts GUARD_CYCLES cycles, then goes to DRIVE.
  - DRIVE: an = all ones except bit[index]=0, unless the digit is blanked (then 4'b1111). dp = ~active_dp[index], forced 1 if blanked. digit_num is unchanged. Lasts DIGIT_CYCLES cycles, then index increments modulo 4 and the state returns to GUARD.
- Sequence after reset release: G cycles dark, D cycles an=1110, G dark, D an=1101, G dark, D an=1011, G dark, D an=0111, repeat. Frame = 4*(G+D) cycles.
- Counter width is $clog2(max(DIGIT_CYCLES,GUARD_CYCLES)+1). The counter resets to 0 on every state change.
- Frame boundary is the last DRIVE cycle of index 3:
  - frame_tick=1 for exactly that cycle.
  - If the shadow is pending, shadow is copied to active on that edge and ready returns to 1 on the following cycle.
  - The first digit-0 GUARD after the boundary already shows new data.
- Handshake:
  - load && ready at an edge captures the inputs into the shadow and sets ready=0 from the next cycle.
  - load while ready=0 is ignored, and the shadow is unchanged.
  - load && ready on the frame-boundary cycle: capture occurs, but the copy to active waits for the next boundary. Data captured on the boundary cycle is never applied in the same frame.
- Blanked digits keep their time slot, so frame timing is independent of the masks.
- No other inputs affect the timing.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k=3..1) is additionally blanked when its active nibble and all higher active nibbles are 0. Digit 0 is never auto-blanked. Example: value 16'h0050 shows digits 1 and 0 only.
- Undefined: only blank_mask blanks digits.
- Auto-blanking is computed from the active registers only, so it also changes only at frame boundaries.

Test Plan (DIGIT_CYCLES=4, GUARD_CYCLES=2, frame=24 cycles):
- Reset then idle 48 cycles -> an pattern 1111x2, 1110x4, 1111x2, 1101x4, 1111x2, 1011x4, 1111x2, 0111x4 repeating; digit_num=0; frame_tick high at cycles 23 and 47 after release.
- Reset, load value=16'hA3F1 at cycle 5 -> ready=0 from cycle 6; frame 0 still shows 0s; ready=1 at cycle 24; digit_num=1,F,3,A during the index 0..3 slots of frame 1.
- Second load while ready=0 with 16'h1234 -> ignored; display shows first loaded value; ready stays 0 until boundary.
- load on frame_tick cycle with value=16'h00C0, blank_mask=4'b0001 -> not shown that frame; next frame digit 0 slot has an=1111; other digits normal.
- dp_mask=4'b0100 loaded -> dp=0 only during DRIVE of digit 2, dp=1 in every GUARD cycle.
- rst_n low mid-DRIVE of digit 2 with pending shadow -> next cycle an=1111, ready=1, active=0, and the sequence restarts at digit 0 GUARD. With SEG_LEADING_ZERO_BLANK_EN, value 16'h0050 -> digits 3,2 dark, digits 1,0 driven.
